// File: rtl/adpll_burst_seq.sv
// Purpose : brings the ADPLL up for one RX/TX burst (FCW write, mode write,
//           lock wait, TX symbol streaming) and powers it down afterwards.
// Latency : sel rises 1 cycle after an accepted start; first TX bit on
//           data_mod SYM_DIV cycles after ACTIVE entry.
// Backpressure: each bus write is held until ready; no timeout on ready.
//           TX bits are consumed only at symbol boundaries (tx_ready pulse).
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_start, i_stop           burst start (IDLE only) / stop (WAIT_LOCK, ACTIVE)
//   i_freq_word, i_mode       FCW and operating mode, sampled on accepted start
//   i_tx_valid, i_tx_data     TX bit source; o_tx_ready pulses on consumption
//   i_channel_lock            lock indication from adpll_ctr
//   o_sel, o_write, o_address, o_data_in, i_ready   adpll_ctr CPU write port
//   o_data_mod                modulation bit to adpll_ctr
//   o_busy, o_active          status
//   o_err_timeout, o_err_unlock, o_underrun   sticky error flags
module adpll_burst_seq #(
  parameter int unsigned SYM_DIV      = 32,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter logic [4:0]  ADDR_FCW     = 5'd1,
  parameter logic [4:0]  ADDR_MODE    = 5'd2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [25:0] i_freq_word,
  input  logic [1:0]  i_mode,
  input  logic        i_tx_valid,
  input  logic        i_tx_data,
  output logic        o_tx_ready,
  input  logic        i_channel_lock,
  output logic        o_sel,
  output logic        o_write,
  output logic [4:0]  o_address,
  output logic [31:0] o_data_in,
  input  logic        i_ready,
  output logic        o_data_mod,
  output logic        o_busy,
  output logic        o_active,
  output logic        o_err_timeout,
  output logic        o_err_unlock,
  output logic        o_underrun
);

  localparam logic [1:0]  MODE_PD   = 2'd0;
  localparam logic [1:0]  MODE_TX   = 2'd3;
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  SYM_LAST  = 8'(SYM_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FCW,
    S_GAP1,
    S_WR_MODE,
    S_WAIT_LOCK,
    S_ACTIVE,
    S_WR_PD
  } state_t;

  state_t      r_state;
  logic [25:0] r_fcw;
  logic [1:0]  r_mode;
  logic        r_sel;
  logic        r_write;
  logic [4:0]  r_address;
  logic [31:0] r_data_in;
  logic [15:0] r_lock_cnt;
  logic [7:0]  r_sym_cnt;
  logic        r_data_mod;
  logic        r_err_timeout;
  logic        r_err_unlock;
  logic        r_underrun;

  state_t      w_state_nxt;
  logic [25:0] w_fcw_nxt;
  logic [1:0]  w_mode_nxt;
  logic        w_sel_nxt;
  logic        w_write_nxt;
  logic [4:0]  w_address_nxt;
  logic [31:0] w_data_in_nxt;
  logic [15:0] w_lock_cnt_nxt;
  logic [7:0]  w_sym_cnt_nxt;
  logic        w_data_mod_nxt;
  logic        w_err_timeout_nxt;
  logic        w_err_unlock_nxt;
  logic        w_underrun_nxt;
  logic        w_tx_ready;
  logic        w_go_pd;

  // Bus outputs are registered from the next state, so sel/address/data_in
  // change only on the edge that enters or leaves a write state and stay
  // stable for as long as ready is withheld.
  always_comb begin
    w_state_nxt       = r_state;
    w_fcw_nxt         = r_fcw;
    w_mode_nxt        = r_mode;
    w_sel_nxt         = r_sel;
    w_write_nxt       = r_write;
    w_address_nxt     = r_address;
    w_data_in_nxt     = r_data_in;
    w_lock_cnt_nxt    = r_lock_cnt;
    w_sym_cnt_nxt     = r_sym_cnt;
    w_data_mod_nxt    = r_data_mod;
    w_err_timeout_nxt = r_err_timeout;
    w_err_unlock_nxt  = r_err_unlock;
    w_underrun_nxt    = r_underrun;
    w_tx_ready        = 1'b0;
    w_go_pd           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_fcw_nxt         = i_freq_word;
          w_mode_nxt        = i_mode;
          w_err_timeout_nxt = 1'b0;
          w_err_unlock_nxt  = 1'b0;
          w_underrun_nxt    = 1'b0;
          if (i_mode != MODE_PD) begin
            w_state_nxt   = S_WR_FCW;
            w_sel_nxt     = 1'b1;
            w_write_nxt   = 1'b1;
            w_address_nxt = ADDR_FCW;
            w_data_in_nxt = {6'b0, i_freq_word};
          end else begin
            w_go_pd = 1'b1;
          end
        end
      end

      S_WR_FCW: begin
        if (i_ready) begin
          w_state_nxt = S_GAP1;
          w_sel_nxt   = 1'b0;
          w_write_nxt = 1'b0;
        end
      end

      // One cycle with sel low separates the two configuration writes.
      S_GAP1: begin
        w_state_nxt   = S_WR_MODE;
        w_sel_nxt     = 1'b1;
        w_write_nxt   = 1'b1;
        w_address_nxt = ADDR_MODE;
        w_data_in_nxt = {30'b0, r_mode};
      end

      S_WR_MODE: begin
        if (i_ready) begin
          w_state_nxt    = S_WAIT_LOCK;
          w_sel_nxt      = 1'b0;
          w_write_nxt    = 1'b0;
          w_lock_cnt_nxt = 16'd0;
        end
      end

      S_WAIT_LOCK: begin
        if (i_stop) begin
          w_go_pd = 1'b1;
        end else if (i_channel_lock) begin
          w_state_nxt   = S_ACTIVE;
          w_sym_cnt_nxt = 8'd0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          w_err_timeout_nxt = 1'b1;
          w_go_pd           = 1'b1;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 16'd1;
        end
      end

      // stop is checked before lock loss so a simultaneous stop masks the
      // unlock error.
      S_ACTIVE: begin
        if (i_stop) begin
          w_go_pd = 1'b1;
        end else if (!i_channel_lock) begin
          w_err_unlock_nxt = 1'b1;
          w_go_pd          = 1'b1;
        end else if (r_sym_cnt == SYM_LAST) begin
          w_sym_cnt_nxt = 8'd0;
          if (r_mode == MODE_TX) begin
            if (i_tx_valid) begin
              w_data_mod_nxt = i_tx_data;
              w_tx_ready     = 1'b1;
            end else begin
              w_underrun_nxt = 1'b1;
            end
          end
        end else begin
          w_sym_cnt_nxt = r_sym_cnt + 8'd1;
        end
      end

      S_WR_PD: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = 1'b0;
          w_write_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase

    // Common power-down entry: mode register written with PD and the
    // modulation bit parked at 0.
    if (w_go_pd) begin
      w_state_nxt    = S_WR_PD;
      w_sel_nxt      = 1'b1;
      w_write_nxt    = 1'b1;
      w_address_nxt  = ADDR_MODE;
      w_data_in_nxt  = 32'd0;
      w_data_mod_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_fcw         <= 26'd0;
      r_mode        <= 2'd0;
      r_sel         <= 1'b0;
      r_write       <= 1'b0;
      r_address     <= 5'd0;
      r_data_in     <= 32'd0;
      r_lock_cnt    <= 16'd0;
      r_sym_cnt     <= 8'd0;
      r_data_mod    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_unlock  <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fcw         <= w_fcw_nxt;
      r_mode        <= w_mode_nxt;
      r_sel         <= w_sel_nxt;
      r_write       <= w_write_nxt;
      r_address     <= w_address_nxt;
      r_data_in     <= w_data_in_nxt;
      r_lock_cnt    <= w_lock_cnt_nxt;
      r_sym_cnt     <= w_sym_cnt_nxt;
      r_data_mod    <= w_data_mod_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_err_unlock  <= w_err_unlock_nxt;
      r_underrun    <= w_underrun_nxt;
    end
  end

  assign o_sel         = r_sel;
  assign o_write       = r_write;
  assign o_address     = r_address;
  assign o_data_in     = r_data_in;
  assign o_data_mod    = r_data_mod;
  assign o_tx_ready    = w_tx_ready;
  assign o_busy        = (r_state != S_IDLE);
  assign o_active      = (r_state == S_ACTIVE);
  assign o_err_timeout = r_err_timeout;
  assign o_err_unlock  = r_err_unlock;
  assign o_underrun    = r_underrun;

endmodule
